// File: rtl/register_bank.sv
// register_bank: DEPTH x WIDTH register file with one write port and two
// registered read ports. Reads have one cycle of latency and see a write
// issued on the same edge (write-first forwarding). Qa0/Qa1 are
// combinationally gated copies of Q0/Q1. VALID records which registers have
// been written since the last CLR.
//
// Reset: CLR is synchronous and active-high. It clears mem, Q0, Q1 and VALID,
// and it wins over a write on the same edge.
//
// Optional feature: define REGISTER_BANK_ZERO_REG_EN to hard-wire register 0
// to zero. When the macro is defined:
//   - writes to address 0 are dropped;
//   - VALID[0] never sets;
//   - reads of address 0 return zero, including the forwarded path.
//
// Handshake: there is none. A write is taken on every rising edge where
// R_W=0 and CLR=0. Read data for the addresses presented at edge N is on
// Q0/Q1 after edge N.
module register_bank #(
   parameter int  WIDTH = 16,
   parameter int  DEPTH = 8,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             CLR,
   input  logic             R_W,
   input  logic [AW-1:0]    WA,
   input  logic [WIDTH-1:0] D,
   input  logic [AW-1:0]    RA0,
   input  logic [AW-1:0]    RA1,
   input  logic             Ea0,
   input  logic             Ea1,
   output logic [WIDTH-1:0] Q0,
   output logic [WIDTH-1:0] Q1,
   output logic [WIDTH-1:0] Qa0,
   output logic [WIDTH-1:0] Qa1,
   output logic [DEPTH-1:0] VALID
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] q0_q, q0_d;
   logic [WIDTH-1:0] q1_q, q1_d;
   logic [DEPTH-1:0] valid_q, valid_d;
   logic             wr_en;

   // Effective write enable: R_W is active-low. With the zero-register
   // feature, a write to address 0 is treated as no write at all.
`ifdef REGISTER_BANK_ZERO_REG_EN
   assign wr_en = ~R_W && (WA != '0);
`else
   assign wr_en = ~R_W;
`endif

   // Next read data, with same-edge write forwarding, and next VALID vector.
   always_comb begin
      q0_d    = mem_q[RA0];
      q1_d    = mem_q[RA1];
      valid_d = valid_q;
      if (wr_en && (RA0 == WA)) q0_d = D;
      if (wr_en && (RA1 == WA)) q1_d = D;
`ifdef REGISTER_BANK_ZERO_REG_EN
      if (RA0 == '0) q0_d = '0;
      if (RA1 == '0) q1_d = '0;
`endif
      if (wr_en) valid_d[WA] = 1'b1;
   end

   // Storage, read registers and VALID. CLR has priority over the write.
   always_ff @(posedge CLK) begin
      if (CLR) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         q0_q    <= '0;
         q1_q    <= '0;
         valid_q <= '0;
      end else begin
         if (wr_en) mem_q[WA] <= D;
         q0_q    <= q0_d;
         q1_q    <= q1_d;
         valid_q <= valid_d;
      end
   end

   assign Q0    = q0_q;
   assign Q1    = q1_q;
   assign VALID = valid_q;

   // Output enables act on the registered data with no clock involvement.
   assign Qa0 = Ea0 ? q0_q : '0;
   assign Qa1 = Ea1 ? q1_q : '0;

endmodule
